// File: rtl/i2s_pkg.sv
// Shared I2S constants and types for the codec link.
package i2s_pkg;

    localparam int AUDIO_WORD_LEN  = 24;
    localparam int AUDIO_FRAME_LEN = 64;
    localparam int CLK_DIVISION    = 14;

    typedef logic [AUDIO_WORD_LEN-1:0] audio_word_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } i2s_chan_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } i2s_rx_state_e;

endpackage

// File: rtl/i2s_edge_sync.sv
// N-stage synchronizer for an asynchronous input, with the previous synced
// value kept so rising/falling edges can be detected in the clk_i domain.
module i2s_edge_sync
    import i2s_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples BCLK/LRCLK/SD on clk_i and recovers
// MSB-first channel words, plus a registered left/right pair.
//   state   | meaning
//   IDLE    | disabled or waiting for the first LRCLK edge
//   CAPTURE | shifting in data bits of the current slot
//   DONE    | word delivered, ignoring padding until the next LRCLK edge
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int RX_AUDIO_WORD_LEN  = AUDIO_WORD_LEN,
    parameter int RX_AUDIO_FRAME_LEN = AUDIO_FRAME_LEN,
    parameter int RX_SYNC_STAGES     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         audio_bclk_i,
    input  logic                         audio_lrclk_i,
    input  logic                         audio_data_i,
    output logic [RX_AUDIO_WORD_LEN-1:0] data_o,
    output logic                         chan_o,
    output logic                         valid_o,
    output logic [RX_AUDIO_WORD_LEN-1:0] left_o,
    output logic [RX_AUDIO_WORD_LEN-1:0] right_o,
    output logic                         pair_valid_o,
    output logic                         slot_err_o
);

    localparam int WL       = RX_AUDIO_WORD_LEN;
    localparam int SLOT_LEN = RX_AUDIO_FRAME_LEN / 2;
    localparam int CNT_W    = $clog2(WL + 1);
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WL);

    if (SLOT_LEN < WL) begin : g_bad_frame
        $error("i2s_receiver: half frame shorter than word length");
    end
    if (RX_SYNC_STAGES < 2) begin : g_bad_sync
        $error("i2s_receiver: at least two synchronizer stages needed");
    end

    logic bclk_rise;
    logic bclk_unused_q, bclk_unused_fall;
    logic lrclk_s, lrclk_unused_rise, lrclk_unused_fall;
    logic sd_s, sd_unused_rise, sd_unused_fall;

    i2s_edge_sync #(.STAGES(RX_SYNC_STAGES)) u_sync_bclk (
        .clk_i (clk_i), .rst_ni(rst_ni), .d_i(audio_bclk_i),
        .q_o   (bclk_unused_q), .rise_o(bclk_rise), .fall_o(bclk_unused_fall)
    );
    i2s_edge_sync #(.STAGES(RX_SYNC_STAGES)) u_sync_lrclk (
        .clk_i (clk_i), .rst_ni(rst_ni), .d_i(audio_lrclk_i),
        .q_o   (lrclk_s), .rise_o(lrclk_unused_rise), .fall_o(lrclk_unused_fall)
    );
    i2s_edge_sync #(.STAGES(RX_SYNC_STAGES)) u_sync_sd (
        .clk_i (clk_i), .rst_ni(rst_ni), .d_i(audio_data_i),
        .q_o   (sd_s), .rise_o(sd_unused_rise), .fall_o(sd_unused_fall)
    );

    i2s_rx_state_e   state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    i2s_chan_e       cur_chan_q, cur_chan_d;
    logic [WL-1:0]   shift_q, shift_d;
    logic            ws_prev_q, ws_prev_d;
    logic [WL-1:0]   data_q, data_d;
    logic            chan_q, chan_d;
    logic            valid_q, valid_d;
    logic [WL-1:0]   hold_q, hold_d;
    logic            left_ok_q, left_ok_d;
    logic [WL-1:0]   left_q, left_d;
    logic [WL-1:0]   right_q, right_d;
    logic            pair_valid_q, pair_valid_d;
    logic            slot_err_q, slot_err_d;
    logic            ws_edge;

    // The rise that carries an LRCLK change holds the previous slot's
    // padding bit, so it only restarts the slot and never shifts data.
    assign ws_edge = bclk_rise && (lrclk_s != ws_prev_q);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        cur_chan_d   = cur_chan_q;
        shift_d      = shift_q;
        ws_prev_d    = ws_prev_q;
        data_d       = data_q;
        chan_d       = chan_q;
        valid_d      = 1'b0;
        hold_d       = hold_q;
        left_ok_d    = left_ok_q;
        left_d       = left_q;
        right_d      = right_q;
        pair_valid_d = 1'b0;
        slot_err_d   = 1'b0;

        if (bclk_rise) begin
            ws_prev_d = lrclk_s;
        end

        if (!enable_i) begin
            state_d   = IDLE;
            left_ok_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ws_edge) begin
                        bit_cnt_d  = '0;
                        cur_chan_d = i2s_chan_e'(lrclk_s);
                        state_d    = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (ws_edge) begin
                        if (bit_cnt_q < WORD_CNT) begin
                            slot_err_d = 1'b1;
                            left_ok_d  = 1'b0;
                        end
                        bit_cnt_d  = '0;
                        cur_chan_d = i2s_chan_e'(lrclk_s);
                    end else if (bit_cnt_q == WORD_CNT) begin
                        data_d  = shift_q;
                        chan_d  = cur_chan_q;
                        valid_d = 1'b1;
                        state_d = DONE;
                        if (cur_chan_q == LEFT) begin
                            hold_d    = shift_q;
                            left_ok_d = 1'b1;
                        end else if (left_ok_q) begin
                            left_d       = hold_q;
                            right_d      = shift_q;
                            pair_valid_d = 1'b1;
                            left_ok_d    = 1'b0;
                        end
                    end else if (bclk_rise) begin
                        shift_d   = {shift_q[WL-2:0], sd_s};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (ws_edge) begin
                        bit_cnt_d  = '0;
                        cur_chan_d = i2s_chan_e'(lrclk_s);
                        state_d    = CAPTURE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            cur_chan_q   <= LEFT;
            shift_q      <= '0;
            ws_prev_q    <= 1'b1;
            data_q       <= '0;
            chan_q       <= 1'b0;
            valid_q      <= 1'b0;
            hold_q       <= '0;
            left_ok_q    <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
            pair_valid_q <= 1'b0;
            slot_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            cur_chan_q   <= cur_chan_d;
            shift_q      <= shift_d;
            ws_prev_q    <= ws_prev_d;
            data_q       <= data_d;
            chan_q       <= chan_d;
            valid_q      <= valid_d;
            hold_q       <= hold_d;
            left_ok_q    <= left_ok_d;
            left_q       <= left_d;
            right_q      <= right_d;
            pair_valid_q <= pair_valid_d;
            slot_err_q   <= slot_err_d;
        end
    end

    assign data_o       = data_q;
    assign chan_o       = chan_q;
    assign valid_o      = valid_q;
    assign left_o       = left_q;
    assign right_o      = right_q;
    assign pair_valid_o = pair_valid_q;
    assign slot_err_o   = slot_err_q;

endmodule
